// File: rtl/alu_mdu_if.sv
// Operand, opcode and result bundle between the execute-stage control logic and alu_mdu.
// The master side drives operands and the start request; the slave side is the arithmetic unit.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output a, b, op, start, input result, z, busy, done, hi, lo);
  modport slave  (input a, b, op, start, output result, z, busy, done, hi, lo);
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit.
// MDU ops run on operand magnitudes for WIDTH cycles; signs are restored when HI/LO are written.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  alu_mdu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;

  always_comb begin
    shamt  = bus.a[SHW-1:0];
    result = '0;
    case (bus.op)
      4'b0000: result = bus.a + bus.b;
      4'b0001: result = bus.a & bus.b;
      4'b0010: result = bus.a | bus.b;
      4'b0011: result = bus.a ^ bus.b;
      4'b0100: result = bus.b >> shamt;
      4'b0101: result = bus.b << shamt;
      4'b0110: result = bus.a - bus.b;
      4'b0111: result = $signed(bus.b) >>> shamt;
      4'b1000: result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1001: result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b1010: result = hi_q;
      4'b1011: result = lo_q;
      default: result = '0;
    endcase
  end

  assign bus.result = result;
  assign bus.z      = ~|result;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

  // One shift-add multiply step and one restoring divide step, both computed every cycle.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_mq;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg, b_neg, sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_acc  = mul_sum[WIDTH:1];
    mul_mq   = {mul_sum[0], mq_q[WIDTH-1:1]};
    prod     = {mul_acc, mul_mq};
    // remainder stays below the divisor, so bit WIDTH of the difference is a pure borrow
    div_sh   = {acc_q, mq_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    div_ok   = ~div_diff[WIDTH];
    div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo  = {mq_q[WIDTH-2:0], div_ok};
    sgn      = ~bus.op[0];
    a_neg    = sgn & bus.a[WIDTH-1];
    b_neg    = sgn & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.op[3:2] == 2'b11)) begin
          state_d  = RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mq_d     = a_mag;
          m_d      = b_mag;
          is_div_d = bus.op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          div0_d   = (bus.b == '0);
        end
      end
      RUN: begin
        cnt_d = cnt_q + SHW'(1);
        acc_d = is_div_q ? div_rem : mul_acc;
        mq_d  = is_div_q ? div_quo : mul_mq;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            lo_d = div0_q ? '1 : (neg_q ? -div_quo : div_quo);
            hi_d = rneg_q ? -div_rem : div_rem;
          end else begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: combinational ops, MDU results, handshake corners, and an 8-bit instance.
module tb_alu_mdu;
  localparam int W = 32;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  alu_mdu_if #(.WIDTH(W)) bus ();
  alu_mdu_if #(.WIDTH(8)) bus8 ();

  alu_mdu #(.WIDTH(W)) dut  (.clock(clock), .reset(reset), .bus(bus));
  alu_mdu #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Bounded wait after the start edge; sample i is taken after edge E_i.
  task automatic wait_done(input int max_cycles, input bit stop_on_done, input bit toggle,
                           output int busy_cnt, output int done_cnt, output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i <= max_cycles; i++) begin
      if (i > 0) step();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (stop_on_done && bus.done === 1'b1) break;
      if (toggle) begin
        bus.a  = $urandom;
        bus.b  = $urandom;
        bus.op = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.a     = 32'd5;
    bus.b     = 32'd3;
    bus8.start = 1'b0;
    bus8.op    = 4'b0000;
    bus8.a     = 8'd0;
    bus8.b     = 8'd0;
    step();
    step();
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_flags got busy/done=%b%b want 00", bus.busy, bus.done);
    end
    total++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_hilo got hi=%h lo=%h want 0/0", bus.hi, bus.lo);
    end
    total++;
    if (bus.result !== 32'd8) begin
      bad++;
      $display("[TB] FAIL reset_comb got %h want 00000008", bus.result);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_comb();
    logic [W-1:0] exp;
    bus.op = 4'b0000; bus.a = 32'd5; bus.b = 32'd3; #1;
    total++;
    if (bus.result !== 32'd8 || bus.z !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add got %h z=%b want 00000008 z=0", bus.result, bus.z);
    end
    bus.op = 4'b0110; bus.a = 32'd7; bus.b = 32'd7; #1;
    total++;
    if (bus.result !== 32'd0 || bus.z !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sub got %h z=%b want 00000000 z=1", bus.result, bus.z);
    end
    bus.op = 4'b0111; bus.a = 32'd4; bus.b = 32'h8000_0000; #1;
    total++;
    if (bus.result !== 32'hF800_0000) begin
      bad++;
      $display("[TB] FAIL sra got %h want f8000000", bus.result);
    end
    bus.op = 4'b1000; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1; #1;
    total++;
    if (bus.result !== 32'd1) begin
      bad++;
      $display("[TB] FAIL slt got %h want 00000001", bus.result);
    end
    bus.op = 4'b1001; #1;
    total++;
    if (bus.result !== 32'd0) begin
      bad++;
      $display("[TB] FAIL sltu got %h want 00000000", bus.result);
    end
    bus.op = 4'b1100; bus.a = 32'd9; bus.b = 32'd9; #1;
    total++;
    if (bus.result !== 32'd0 || bus.z !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mdu_op_result got %h want 00000000", bus.result);
    end
    for (int i = 0; i < 1000; i++) begin
      bus.op = 4'($urandom_range(0, 6));
      bus.a  = $urandom;
      bus.b  = $urandom;
      case (bus.op)
        4'd0: exp = bus.a + bus.b;
        4'd1: exp = bus.a & bus.b;
        4'd2: exp = bus.a | bus.b;
        4'd3: exp = bus.a ^ bus.b;
        4'd4: exp = bus.b >> bus.a[4:0];
        4'd5: exp = bus.b << bus.a[4:0];
        default: exp = bus.a - bus.b;
      endcase
      #1;
      total++;
      if (bus.result !== exp || bus.z !== (exp == 0)) begin
        bad++;
        $display("[TB] FAIL legacy op=%0d a=%h b=%h got %h want %h", bus.op, bus.a, bus.b, bus.result, exp);
      end
    end
    step();
  endtask

  task automatic test_multu();
    int bc, dc, da;
    launch(4'b1101, 32'hFFFF_FFFF, 32'd2);
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (bc !== W || da !== W) begin
      bad++;
      $display("[TB] FAIL multu_timing got busy=%0d done_at=%0d want %0d/%0d", bc, da, W, W);
    end
    total++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin
      bad++;
      $display("[TB] FAIL multu_val got %h_%h want 00000001_fffffffe", bus.hi, bus.lo);
    end
    step();
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_pulse got done=%b want 0", bus.done);
    end
    bus.op = 4'b1010; #1;
    total++;
    if (bus.result !== 32'd1) begin
      bad++;
      $display("[TB] FAIL mfhi got %h want 00000001", bus.result);
    end
    bus.op = 4'b1011; #1;
    total++;
    if (bus.result !== 32'hFFFF_FFFE) begin
      bad++;
      $display("[TB] FAIL mflo got %h want fffffffe", bus.result);
    end
    step();
  endtask

  task automatic test_mult_toggle();
    int bc, dc, da;
    launch(4'b1100, 32'hFFFF_FFFD, 32'd5);
    wait_done(W + 8, 1'b1, 1'b1, bc, dc, da);
    total++;
    if (dc !== 1 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      bad++;
      $display("[TB] FAIL mult_signed got done=%0d %h_%h want 1 ffffffff_fffffff1", dc, bus.hi, bus.lo);
    end
    step();
  endtask

  task automatic test_div();
    int bc, dc, da;
    launch(4'b1110, 32'hFFFF_FFF9, 32'd2);
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (dc !== 1 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      bad++;
      $display("[TB] FAIL div_neg got lo=%h hi=%h want fffffffd/ffffffff", bus.lo, bus.hi);
    end
    step();
    launch(4'b1111, 32'd9, 32'd0);
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (dc !== 1 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd9) begin
      bad++;
      $display("[TB] FAIL divu_zero got lo=%h hi=%h want ffffffff/00000009", bus.lo, bus.hi);
    end
    step();
    launch(4'b1110, 32'hFFFF_FFF9, 32'd0);
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (dc !== 1 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFF9) begin
      bad++;
      $display("[TB] FAIL div_zero got lo=%h hi=%h want ffffffff/fffffff9", bus.lo, bus.hi);
    end
    step();
    launch(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (dc !== 1 || bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
      bad++;
      $display("[TB] FAIL div_min got lo=%h hi=%h want 80000000/00000000", bus.lo, bus.hi);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    int bc, dc, da;
    launch(4'b1101, 32'd3, 32'd4);
    wait_done(5, 1'b0, 1'b0, bc, dc, da);
    bus.op = 4'b1101; bus.a = 32'd7; bus.b = 32'd7; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(W + 10, 1'b0, 1'b0, bc, dc, da);
    total++;
    if (dc !== 1 || bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
      bad++;
      $display("[TB] FAIL ignore_start got dones=%0d lo=%h hi=%h want 1 0000000c/00000000", dc, bus.lo, bus.hi);
    end
  endtask

  task automatic test_reset_abort();
    int bc, dc, da;
    launch(4'b1111, 32'd100, 32'd3);
    wait_done(9, 1'b0, 1'b0, bc, dc, da);
    reset = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_abort got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    reset = 1'b0;
    wait_done(W + 10, 1'b0, 1'b0, bc, dc, da);
    total++;
    if (dc !== 0 || bc !== 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet got dones=%0d busy=%0d want 0/0", dc, bc);
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc, da;
    launch(4'b1111, 32'd100, 32'd7);
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (da !== W || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      bad++;
      $display("[TB] FAIL divu_first got done_at=%0d lo=%h hi=%h want %0d 0000000e/00000002", da, bus.lo, bus.hi, W);
    end
    launch(4'b1101, 32'd6, 32'd7);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_on_done got busy=%b want 1", bus.busy);
    end
    wait_done(W + 8, 1'b1, 1'b0, bc, dc, da);
    total++;
    if (da !== W || bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
      bad++;
      $display("[TB] FAIL second_op got done_at=%0d lo=%h hi=%h want %0d 0000002a/00000000", da, bus.lo, bus.hi, W);
    end
    step();
  endtask

  task automatic test_width8();
    int bc;
    int da;
    bus8.op = 4'b0111; bus8.a = 8'd1; bus8.b = 8'h80; #1;
    total++;
    if (bus8.result !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL w8_sra got %h want c0", bus8.result);
    end
    bus8.op = 4'b1101; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bc = 0;
    da = -1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) step();
      if (bus8.busy === 1'b1) bc++;
      if (bus8.done === 1'b1) begin
        da = i;
        break;
      end
    end
    total++;
    if (bc !== 8 || da !== 8) begin
      bad++;
      $display("[TB] FAIL w8_timing got busy=%0d done_at=%0d want 8/8", bc, da);
    end
    total++;
    if (bus8.hi !== 8'hFE || bus8.lo !== 8'h01) begin
      bad++;
      $display("[TB] FAIL w8_multu got %h_%h want fe_01", bus8.hi, bus8.lo);
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_comb();
    test_multu();
    test_mult_toggle();
    test_div();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit for the pipelined MIPS core. It replaces the single-cycle 3-bit-opcode ALU and keeps opcodes 0000–0110 bit-compatible with it. It adds arithmetic shift, set-less-than, HI/LO moves, and an iterative multiply/divide unit with a start/busy/done handshake. The pipeline control unit stalls ID/EX on `busy`.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8. SHW = log2(WIDTH) is derived.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- a  in  WIDTH  operand A; shift amount for shifts
- b  in  WIDTH  operand B; value shifted for shifts
- op  in  4  operation select
- start  in  1  launch multi-cycle op (op 1100–1111)
- result  out  WIDTH  combinational result
- z  out  1  ~|result
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse when hi/lo are updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Combinational ops (result valid in the same cycle; start is ignored):
  - 0000 add a+b; 0001 and; 0010 or; 0011 xor
  - 0100 srl b>>a[SHW-1:0]; 0101 sll b<<a[SHW-1:0]; 0110 sub a−b
  - 0111 sra (b arithmetic-right by a[SHW-1:0])
  - 1000 slt (signed a<b → 1, else 0); 1001 sltu (unsigned)
  - 1010 mfhi → hi; 1011 mflo → lo
- Multi-cycle ops (result = 0 while selected):
  - 1100 mult, 1101 multu: {hi,lo} = a×b (2·WIDTH bits).
  - 1110 div, 1111 divu: lo = quotient, hi = remainder.
- Add/sub wrap modulo 2^WIDTH. There is no overflow flag.
- Multiply is radix-2 shift-add on magnitudes. Signed: operands are converted to absolute values, and the 2·WIDTH product is negated if the signs differ.
- Divide is restoring, one quotient bit per cycle, on magnitudes.
  - Signed quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (either signedness): lo = all ones, hi = a.
  - Signed MIN/−1: lo = MIN, hi = 0.
- FSM states: IDLE, RUN.
  - IDLE→RUN when start=1 and op ∈ 1100–1111. Operands and op are latched at that edge, and the iteration counter is cleared.
  - RUN→IDLE when the counter reaches WIDTH−1. hi/lo are written at that edge and done is set.
- Changes on a, b or op during RUN have no effect on the operation in flight.
- start while busy: ignored, with no queueing.
- start with a combinational op: ignored.
- mfhi/mflo during RUN return the old hi/lo. Avoiding this hazard is the pipeline's job (stall on busy).

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. result and z follow inputs combinationally, including during reset.
- Multi-cycle latency, taking the start edge as E0:
  - busy=1 from after E0 through E_WIDTH; that is exactly WIDTH cycles.
  - At E_WIDTH: hi/lo are updated, busy falls, and done=1 for one cycle.
- A new start is accepted in the cycle done is high, since busy=0 then. The back-to-back issue interval is WIDTH+1 edges.
- Reset mid-operation: abort. hi/lo are cleared to 0, busy=0 at the next cycle, and done is not pulsed.
- Reset and start in the same cycle: reset wins.
- done is never asserted without a preceding accepted start.

## Test plan
- Combinational sweep (WIDTH=32):
  - add 5,3 → 8, z=0
  - sub 7,7 → 0, z=1
  - sra a=4, b=0x80000000 → 0xF8000000
  - slt a=0xFFFFFFFF, b=1 → 1; sltu with the same operands → 0
  - op 0000–0110 match the legacy ALU on 1000 random vectors.
- multu a=0xFFFFFFFF, b=2, start for 1 cycle → busy high for exactly 32 cycles, done pulse 1 cycle, hi=0x00000001, lo=0xFFFFFFFE. mfhi/mflo then return those values.
- mult a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Operands toggled during busy do not change the result.
- Divide cases:
  - div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - divu a=9, b=0 → lo=0xFFFFFFFF, hi=9
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0
- Handshake corners:
  - A second start during busy is ignored (single done, first op's result).
  - reset at cycle 10 of a div → busy=0 next cycle, hi=lo=0, no done.
  - start on the done cycle is accepted.
- WIDTH=8 instance: multu 0xFF×0xFF → hi=0xFE, lo=0x01, busy exactly 8 cycles. sra a=1, b=0x80 → 0xC0.
